// File: rtl/div_result_buffer.sv
// div_result_buffer
//   Result FIFO behind the fixed-latency pipelined divider. Each divider
//   out_valid is captured as {quot, remd, div_by_zero} and presented to the
//   consumer over valid/ready. Upstream may only start a divide while a slot
//   is reserved for its result (level + inflight < DEPTH).
//
//   Optional feature macro: DIV_ZERO_DROP_EN
//     defined   : divide-by-zero results are discarded (still retire their
//                 credit); m_zero is constant 0.
//     undefined : divide-by-zero results are stored with m_zero=1.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   issue / issue_ok         upstream divide start pulse / credit available
//   div_valid, div_quot,
//   div_remd, div_zero       divider result
//   m_valid, m_ready,
//   m_quot, m_remd, m_zero   head entry to consumer
//   level, inflight          stored entries / divides outstanding
//   overflow                 sticky: result arrived while full and was lost
module div_result_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   output logic              issue_ok,
   input  logic              div_valid,
   input  logic [DATA_W-1:0] div_quot,
   input  logic [DATA_W-1:0] div_remd,
   input  logic              div_zero,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_quot,
   output logic [DATA_W-1:0] m_remd,
   output logic              m_zero,
   output logic [CNT_W-1:0]  level,
   output logic [CNT_W-1:0]  inflight,
   output logic              overflow
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W:0]   DEPTH_S = (CNT_W+1)'(DEPTH);

   typedef struct packed {
      logic              zero;
      logic [DATA_W-1:0] quot;
      logic [DATA_W-1:0] remd;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            new_entry;
   entry_t            head;
   entry_t            last_head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_req;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic              issue_acc;

`ifdef DIV_ZERO_DROP_EN
   assign push_req  = div_valid & ~div_zero;
   assign new_entry = '{zero: 1'b0, quot: div_quot, remd: div_remd};
`else
   assign push_req  = div_valid;
   assign new_entry = '{zero: div_zero, quot: div_quot, remd: div_remd};
`endif

   assign full      = (level == DEPTH_C);
   assign m_valid   = (level != '0);
   assign pop       = m_valid & m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign wr_en     = push_req & (~full | pop);
   assign issue_ok  = ({1'b0, level} + {1'b0, inflight}) < DEPTH_S;
   assign issue_acc = issue & issue_ok;

   // While empty the outputs keep showing the most recently consumed entry
   // (zero straight after reset).
   assign head   = m_valid ? mem[rd_ptr] : last_head;
   assign m_quot = head.quot;
   assign m_remd = head.remd;
   assign m_zero = head.zero;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         inflight  <= '0;
         overflow  <= 1'b0;
         last_head <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            last_head <= mem[rd_ptr];
         end

         case ({wr_en, pop})
            2'b10:   level <= level + CNT_W'(1);
            2'b01:   level <= level - CNT_W'(1);
            default: level <= level;
         endcase

         // A returning result with nothing outstanding does not underflow.
         if (issue_acc && div_valid)
            inflight <= inflight;
         else if (issue_acc)
            inflight <= inflight + CNT_W'(1);
         else if (div_valid && inflight != '0)
            inflight <= inflight - CNT_W'(1);

         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_result_buffer.sv
module tb_div_result_buffer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue;
   logic              issue_ok;
   logic              div_valid;
   logic [DATA_W-1:0] div_quot;
   logic [DATA_W-1:0] div_remd;
   logic              div_zero;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_quot;
   logic [DATA_W-1:0] m_remd;
   logic              m_zero;
   logic [CNT_W-1:0]  level;
   logic [CNT_W-1:0]  inflight;
   logic              overflow;

   div_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
      .div_valid(div_valid), .div_quot(div_quot), .div_remd(div_remd),
      .div_zero(div_zero), .m_valid(m_valid), .m_ready(m_ready),
      .m_quot(m_quot), .m_remd(m_remd), .m_zero(m_zero),
      .level(level), .inflight(inflight), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } exp_t;

   vec_t vecs [6];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic bit stores(input vec_t v);
`ifdef DIV_ZERO_DROP_EN
      return !v.z;
`else
      return 1'b1;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural divider output for one cycle; expected entry comes from the table.
   task automatic drive_result(input vec_t v, input bit expect_store);
      div_valid = 1'b1;
      div_quot  = (v.b == 0) ? 8'd0 : v.a / v.b;
      div_remd  = (v.b == 0) ? 8'd0 : v.a % v.b;
      div_zero  = (v.b == 0);
      if (expect_store) sb.push_back('{q: v.q, r: v.r, z: v.z});
      step();
      div_valid = 1'b0;
      div_quot  = '0;
      div_remd  = '0;
      div_zero  = 1'b0;
   endtask

   // Scoreboard: every accepted head must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pop: got q=%0d r=%0d, expected no output", m_quot, m_remd);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("head_quot", 32'(m_quot), 32'(e.q));
            chk("head_remd", 32'(m_remd), 32'(e.r));
            chk("head_zero", 32'(m_zero), 32'(e.z));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{a: 8'd100, b: 8'd7,  q: 8'd14, r: 8'd2,  z: 1'b0};
      vecs[1] = '{a: 8'd9,   b: 8'd3,  q: 8'd3,  r: 8'd0,  z: 1'b0};
      vecs[2] = '{a: 8'd5,   b: 8'd9,  q: 8'd0,  r: 8'd5,  z: 1'b0};
      vecs[3] = '{a: 8'd255, b: 8'd16, q: 8'd15, r: 8'd15, z: 1'b0};
      vecs[4] = '{a: 8'd200, b: 8'd10, q: 8'd20, r: 8'd0,  z: 1'b0};
      vecs[5] = '{a: 8'd42,  b: 8'd0,  q: 8'd0,  r: 8'd0,  z: 1'b1};

      rst = 1'b1; issue = 1'b0; div_valid = 1'b0; div_quot = '0;
      div_remd = '0; div_zero = 1'b0; m_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // reset state
      chk("rst_m_valid",  32'(m_valid),  0);
      chk("rst_level",    32'(level),    0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_issue_ok", 32'(issue_ok), 1);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_m_quot",   32'(m_quot),   0);

      // credits: four issues exhaust DEPTH, fifth is ignored
      for (int i = 0; i < DEPTH; i++) begin
         issue = 1'b1; step(); issue = 1'b0;
         chk("credit_inflight", 32'(inflight), 32'(i + 1));
      end
      chk("credit_exhausted", 32'(issue_ok), 0);
      issue = 1'b1; step(); issue = 1'b0;
      chk("credit_5th_ignored", 32'(inflight), 4);

      // results return with consumer stalled: credit stays consumed
      for (int i = 0; i < DEPTH; i++) begin
         drive_result(vecs[i], 1'b1);
         chk("fill_issue_ok", 32'(issue_ok), 0);
      end
      chk("fill_level",    32'(level),    4);
      chk("fill_inflight", 32'(inflight), 0);

      // full: push and pop in the same cycle
      m_ready = 1'b1;
      drive_result(vecs[4], 1'b1);
      chk("full_pp_level",    32'(level),    4);
      chk("full_pp_overflow", 32'(overflow), 0);
      chk("full_pp_inflight", 32'(inflight), 0);
      for (int k = 0; k < 20 && level != 0; k++) step();
      m_ready = 1'b0;
      chk("drain_level",     32'(level),     0);
      chk("drain_sb_empty",  32'(sb.size()), 0);
      chk("hold_m_valid",    32'(m_valid),   0);
      chk("hold_m_quot",     32'(m_quot),    32'(vecs[4].q));
      chk("hold_m_remd",     32'(m_remd),    32'(vecs[4].r));

      // table: issue, divider latency, result visible one cycle later
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue = 1'b1; step(); issue = 1'b0;
         chk("tbl_inflight_up", 32'(inflight), 1);
         chk("tbl_issue_ok",    32'(issue_ok), 1);
         step();
         chk("tbl_idle_valid",  32'(m_valid),  0);
         drive_result(vecs[i], stores(vecs[i]));
         chk("tbl_latency_valid", 32'(m_valid), 32'(stores(vecs[i])));
         chk("tbl_inflight_dn",   32'(inflight), 0);
         step();
         chk("tbl_level_after", 32'(level), 0);
      end
      m_ready = 1'b0;
      chk("tbl_sb_empty", 32'(sb.size()), 0);

      // overflow: result lost while full, order of stored data kept
      for (int i = 0; i < DEPTH; i++) drive_result(vecs[i], 1'b1);
      chk("ovf_level_full", 32'(level),    4);
      chk("ovf_before",     32'(overflow), 0);
      drive_result(vecs[4], 1'b0);
      chk("ovf_set",        32'(overflow), 1);
      chk("ovf_level",      32'(level),    4);
      chk("ovf_head_quot",  32'(m_quot),   32'(vecs[0].q));
      step();
      chk("ovf_sticky",     32'(overflow), 1);

      // asynchronous reset mid-stream
      rst = 1'b1;
      #2;
      chk("mrst_level",    32'(level),    0);
      chk("mrst_m_valid",  32'(m_valid),  0);
      chk("mrst_overflow", 32'(overflow), 0);
      chk("mrst_inflight", 32'(inflight), 0);
      chk("mrst_issue_ok", 32'(issue_ok), 1);
      chk("mrst_m_quot",   32'(m_quot),   0);
      sb.delete();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_level", 32'(level), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
